// File: rtl/stream_packer_if.sv
// Stream bundle for stream_packer: narrow upstream beats in, packed wide
// words out. The master view belongs to the packer itself. The slave view
// belongs to whatever feeds the narrow beats and drains the wide words.
interface stream_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
);
    logic                          input_ready;
    logic                          input_valid;
    logic [DATA_WIDTH-1:0]         input_data;
    logic                          input_last;
    logic                          output_ready;
    logic                          output_valid;
    logic [DATA_WIDTH*RATIO-1:0]   output_data;
    logic [RATIO-1:0]              output_keep;
    logic                          output_last;

    modport master (
        output input_ready,
        input  input_valid,
        input  input_data,
        input  input_last,
        input  output_ready,
        output output_valid,
        output output_data,
        output output_keep,
        output output_last
    );

    modport slave (
        input  input_ready,
        output input_valid,
        output input_data,
        output input_last,
        output output_ready,
        input  output_valid,
        input  output_data,
        input  output_keep,
        input  output_last
    );
endinterface

// File: rtl/stream_packer.sv
// Width-converting packer: gathers RATIO narrow beats, little-endian by lane,
// into one wide word. Packets that end early flush as partial words. The keep
// mask marks the populated lanes. All outputs except input_ready come from
// registers. input_ready is combinational, so a word being drained can be
// replaced in the same cycle with no bubble.
module stream_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic              clk,
    input  logic              reset,
    stream_packer_if.master   bus
);
    localparam int WORD_WIDTH = DATA_WIDTH * RATIO;
    localparam int IDX_W      = (RATIO > 2) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    // Assembly state: the partially built word and its populated lanes.
    logic [IDX_W-1:0]      lane_idx_r;
    logic [WORD_WIDTH-1:0] asm_data_r;
    logic [RATIO-1:0]      asm_keep_r;

    // Output register presented downstream.
    logic                  out_valid_r;
    logic [WORD_WIDTH-1:0] out_data_r;
    logic [RATIO-1:0]      out_keep_r;
    logic                  out_last_r;

    logic                  input_ready_s;
    logic                  accept_s;
    logic                  final_s;
    logic                  drain_s;
    logic [WORD_WIDTH-1:0] merged_data_s;
    logic [RATIO-1:0]      merged_keep_s;

    // Handshake decode: a held output word blocks every input beat, including
    // non-final ones, so assembly state cannot run ahead of a stalled output.
    always_comb begin
        input_ready_s = ~reset & (~out_valid_r | bus.output_ready);
        accept_s      = bus.input_valid & input_ready_s;
        final_s       = accept_s & ((lane_idx_r == LAST_IDX) | bus.input_last);
        drain_s       = out_valid_r & bus.output_ready;
    end

    // Assembly contents with the current beat dropped into its lane.
    always_comb begin
        merged_data_s = asm_data_r;
        merged_keep_s = asm_keep_r;
        for (int k = 0; k < RATIO; k++) begin
            if (lane_idx_r == IDX_W'(k)) begin
                merged_data_s[k*DATA_WIDTH +: DATA_WIDTH] = bus.input_data;
                merged_keep_s[k]                          = 1'b1;
            end else begin
                merged_data_s[k*DATA_WIDTH +: DATA_WIDTH] = asm_data_r[k*DATA_WIDTH +: DATA_WIDTH];
                merged_keep_s[k]                          = asm_keep_r[k];
            end
        end
    end

    // Assembly and output registers. A final beat loads the output register
    // and clears the assembly on the same edge. Lanes above the final index
    // stay zero because the assembly is cleared after each word.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_idx_r  <= '0;
            asm_data_r  <= '0;
            asm_keep_r  <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_keep_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (final_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= merged_data_s;
            out_keep_r  <= merged_keep_s;
            out_last_r  <= bus.input_last;
            lane_idx_r  <= '0;
            asm_data_r  <= '0;
            asm_keep_r  <= '0;
        end else begin
            if (drain_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            if (accept_s) begin
                asm_data_r <= merged_data_s;
                asm_keep_r <= merged_keep_s;
                lane_idx_r <= lane_idx_r + IDX_W'(1);
            end else begin
                asm_data_r <= asm_data_r;
                asm_keep_r <= asm_keep_r;
                lane_idx_r <= lane_idx_r;
            end
        end
    end

    assign bus.input_ready  = input_ready_s;
    assign bus.output_valid = out_valid_r;
    assign bus.output_data  = out_data_r;
    assign bus.output_keep  = out_keep_r;
    assign bus.output_last  = out_last_r;
endmodule

// File: tb/tb_stream_packer.sv
// Directed bench for stream_packer. A reference packing model pushes expected
// words into a scoreboard as beats are accepted. A monitor pops the expected
// word and compares it whenever a word transfers downstream.
module tb_stream_packer;
    localparam int DW = 8;
    localparam int R  = 4;
    localparam int WW = DW * R;

    typedef struct packed {
        logic [WW-1:0] data;
        logic [R-1:0]  keep;
        logic          last;
    } word_t;

    logic clk = 1'b0;
    logic reset;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    stream_packer_if #(.DATA_WIDTH(DW), .RATIO(R)) bus ();

    stream_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    word_t         exp_q[$];
    int            xfer_cyc[$];
    logic [WW-1:0] m_data;
    logic [R-1:0]  m_keep;
    int            m_idx;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            words_seen = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data = '0;
        m_keep = '0;
        m_idx  = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [DW-1:0] d, input logic l);
        word_t w;
        m_data[m_idx*DW +: DW] = d;
        m_keep[m_idx]          = 1'b1;
        if (m_idx == R - 1 || l) begin
            w.data = m_data;
            w.keep = m_keep;
            w.last = l;
            exp_q.push_back(w);
            m_data = '0;
            m_keep = '0;
            m_idx  = 0;
        end else begin
            m_idx++;
        end
    endtask

    // Offer one beat until accepted. This is called at a falling edge and
    // returns at the falling edge after the accepting rising edge.
    task automatic send(input logic [DW-1:0] d, input logic l);
        bit ok;
        bit done;
        done = 1'b0;
        bus.input_valid = 1'b1;
        bus.input_data  = d;
        bus.input_last  = l;
        for (int t = 0; t < 100 && !done; t++) begin
            #1;
            ok = bus.input_ready;
            @(posedge clk);
            if (ok) begin
                model_accept(d, l);
                done = 1'b1;
            end
            @(negedge clk);
        end
        check("send_accept", 64'(done), 64'd1);
        bus.input_valid = 1'b0;
        bus.input_last  = 1'b0;
    endtask

    // Cycle counter used to measure output cadence.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: sample just before the rising edge and score each transfer.
    always @(negedge clk) begin
        word_t w;
        #4;
        if (!reset && bus.output_valid && bus.output_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 64'd1, 64'd0);
            end else begin
                w = exp_q.pop_front();
                check("sb_data", 64'(bus.output_data), 64'(w.data));
                check("sb_keep", 64'(bus.output_keep), 64'(w.keep));
                check("sb_last", 64'(bus.output_last), 64'(w.last));
            end
            words_seen++;
            xfer_cyc.push_back(cyc);
        end
    end

    // Directed stimulus sequence.
    initial begin
        int start_cyc;
        int n0;
        int nx;
        bus.input_valid  = 1'b0;
        bus.input_data   = '0;
        bus.input_last   = 1'b0;
        bus.output_ready = 1'b1;
        reset            = 1'b1;
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(bus.output_valid), 64'd0);
        check("rst_keep",  64'(bus.output_keep),  64'd0);
        check("rst_last",  64'(bus.output_last),  64'd0);
        check("rst_data",  64'(bus.output_data),  64'd0);
        check("rst_ready", 64'(bus.input_ready),  64'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 64'(bus.input_ready), 64'd1);
        @(negedge clk);
        check("post_rst_valid", 64'(bus.output_valid), 64'd0);

        // Full word, no last.
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        check("full_valid", 64'(bus.output_valid), 64'd1);
        check("full_data",  64'(bus.output_data),  64'h44332211);
        check("full_keep",  64'(bus.output_keep),  64'hF);
        check("full_last",  64'(bus.output_last),  64'd0);
        @(negedge clk);
        check("full_one_cycle", 64'(bus.output_valid), 64'd0);

        // Two-beat packet, partial flush.
        send(8'hA1, 1'b0);
        send(8'hB2, 1'b1);
        check("part_data", 64'(bus.output_data), 64'h0000B2A1);
        check("part_keep", 64'(bus.output_keep), 64'h3);
        check("part_last", 64'(bus.output_last), 64'd1);

        // Single-beat packet accepted while the previous word drains.
        send(8'h5C, 1'b1);
        check("single_valid", 64'(bus.output_valid), 64'd1);
        check("single_data",  64'(bus.output_data),  64'h0000005C);
        check("single_keep",  64'(bus.output_keep),  64'h1);
        check("single_last",  64'(bus.output_last),  64'd1);
        @(negedge clk);

        // Backpressure: word held for five cycles, upstream keeps offering.
        bus.output_ready = 1'b0;
        send(8'hC0, 1'b0);
        send(8'hC1, 1'b0);
        send(8'hC2, 1'b0);
        send(8'hC3, 1'b0);
        bus.input_valid = 1'b1;
        bus.input_data  = 8'h99;
        bus.input_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("stall_ready", 64'(bus.input_ready),  64'd0);
            check("stall_valid", 64'(bus.output_valid), 64'd1);
            check("stall_data",  64'(bus.output_data),  64'hC3C2C1C0);
            check("stall_keep",  64'(bus.output_keep),  64'hF);
            @(negedge clk);
        end
        bus.output_ready = 1'b1;
        #1;
        check("release_ready", 64'(bus.input_ready), 64'd1);
        send(8'h99, 1'b1);
        check("after_stall_data", 64'(bus.output_data), 64'h00000099);
        check("after_stall_keep", 64'(bus.output_keep), 64'h1);
        @(negedge clk);

        // Continuous streaming: 16 beats, one word per four cycles.
        start_cyc = cyc;
        n0        = words_seen;
        for (int i = 0; i < 16; i++) begin
            send(8'($urandom), 1'b0);
        end
        check("stream_cycles", 64'(cyc - start_cyc), 64'd16);
        @(negedge clk);
        check("stream_words", 64'(words_seen - n0), 64'd4);
        nx = xfer_cyc.size();
        if (nx >= 4) begin
            for (int i = nx - 3; i < nx; i++) begin
                check("stream_gap", 64'(xfer_cyc[i] - xfer_cyc[i-1]), 64'd4);
            end
        end else begin
            check("stream_xfers", 64'(nx), 64'd4);
        end

        // Reset mid-word discards the assembly.
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_ready", 64'(bus.input_ready),  64'd0);
        check("midrst_valid", 64'(bus.output_valid), 64'd0);
        @(negedge clk);
        check("midrst_valid_after", 64'(bus.output_valid), 64'd0);
        model_reset();
        reset = 1'b0;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        check("postrst_data", 64'(bus.output_data), 64'h04030201);
        check("postrst_keep", 64'(bus.output_keep), 64'hF);
        check("postrst_last", 64'(bus.output_last), 64'd0);
        repeat (2) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
